// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use detection,
// MULT/DIV serialisation with HI/LO interlock, branch flush of IF/ID and
// a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_md_op,
  input  logic             id_md_div,
  input  logic             id_hilo_acc,
  input  logic             id_br_taken,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_wreg,
  output logic             pc_bubble,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             md_start,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  // md_cnt must hold DIV_CYC-1
  localparam int unsigned MD_CNT_W = (DIV_CYC > 2) ? $clog2(DIV_CYC) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]          r_md_state;
  logic [0:0]          w_md_state_nxt;
  logic [MD_CNT_W-1:0] r_md_cnt;
  logic [MD_CNT_W-1:0] w_md_cnt_nxt;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic w_load_use;
  logic w_md_busy;
  logic w_md_hz;
  logic w_stall;
  logic w_md_start;

  // Hazard detection: load-use against EX destination, HI/LO interlock on busy MD unit
  always_comb begin
    w_load_use = 1'b0;
    w_md_busy  = 1'b0;
    w_md_hz    = 1'b0;
    w_stall    = 1'b0;
    w_md_start = 1'b0;

    // $0 is hard-wired zero, so a load targeting it never creates a dependency
    w_load_use = ex_mem_read && (ex_wreg != 5'd0) &&
                 ((id_use_rs && (id_rs == ex_wreg)) ||
                  (id_use_rt && (id_rt == ex_wreg)));
    w_md_busy  = (r_md_state == S_BUSY);
    w_md_hz    = w_md_busy && (id_md_op || id_hilo_acc);
    w_stall    = w_load_use || w_md_hz;
    // Load-use blocks the start too, so the MD op launches only once its operands are ready
    w_md_start = id_md_op && !w_stall && (r_md_state == S_IDLE);
  end

  // Pipeline control outputs; reset forces every strobe low in the same cycle
  always_comb begin
    pc_bubble  = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    md_start   = 1'b0;
    md_busy    = 1'b0;

    if (!reset) begin
      pc_bubble  = w_stall;
      ifid_stall = w_stall;
      idex_flush = w_stall;
      // Branch is ignored while stalled; ID re-presents it once the stall clears
      ifid_flush = id_br_taken && !w_stall;
      md_start   = w_md_start;
      md_busy    = w_md_busy;
    end
  end

  assign stall_cnt = r_stall_cnt;

  // MD unit occupancy: next-state and countdown
  always_comb begin
    w_md_state_nxt = r_md_state;
    w_md_cnt_nxt   = r_md_cnt;

    case (r_md_state)
      S_IDLE: begin
        if (w_md_start) begin
          w_md_state_nxt = S_BUSY;
          w_md_cnt_nxt   = id_md_div ? MD_CNT_W'(DIV_CYC - 1)
                                     : MD_CNT_W'(MULT_CYC - 1);
        end
      end
      S_BUSY: begin
        // The start cycle counts toward latency, so busy spans LAT-1 cycles
        if (r_md_cnt <= MD_CNT_W'(1)) begin
          w_md_state_nxt = S_IDLE;
          w_md_cnt_nxt   = '0;
        end else begin
          w_md_cnt_nxt   = r_md_cnt - MD_CNT_W'(1);
        end
      end
      default: begin
        w_md_state_nxt = S_IDLE;
        w_md_cnt_nxt   = '0;
      end
    endcase
  end

  // MD state register; reset aborts any op in flight
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_md_state <= S_IDLE;
      r_md_cnt   <= '0;
    end else begin
      r_md_state <= w_md_state_nxt;
      r_md_cnt   <= w_md_cnt_nxt;
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a driver applies one directed
// vector per cycle and queues its hand-computed response; a monitor pops
// and compares on the falling edge. A 4-bit stall counter exposes saturation.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CW = 4;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       md_op;
    logic       md_div;
    logic       hilo;
    logic       br;
    logic       ex_rd;
    logic [4:0] ex_w;
  } stim_t;

  typedef struct {
    logic [5:0]    bits;  // {pc_bubble, ifid_stall, ifid_flush, idex_flush, md_start, md_busy}
    logic [CW-1:0] cnt;
    string         nm;
  } exp_t;

  localparam logic [5:0] E_NONE   = 6'b000000;
  localparam logic [5:0] E_STALL  = 6'b110100;
  localparam logic [5:0] E_STALLB = 6'b110101;
  localparam logic [5:0] E_START  = 6'b000010;
  localparam logic [5:0] E_BUSY   = 6'b000001;
  localparam logic [5:0] E_FLUSH  = 6'b001000;

  logic          CLK = 1'b0;
  logic          reset;
  logic [4:0]    id_rs, id_rt, ex_wreg;
  logic          id_use_rs, id_use_rt, id_md_op, id_md_div, id_hilo_acc;
  logic          id_br_taken, ex_mem_read;
  logic          pc_bubble, ifid_stall, ifid_flush, idex_flush, md_start, md_busy;
  logic [CW-1:0] stall_cnt;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(CW)) dut (
    .CLK(CLK), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_md_op(id_md_op), .id_md_div(id_md_div), .id_hilo_acc(id_hilo_acc),
    .id_br_taken(id_br_taken), .ex_mem_read(ex_mem_read), .ex_wreg(ex_wreg),
    .pc_bubble(pc_bubble), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .md_start(md_start), .md_busy(md_busy),
    .stall_cnt(stall_cnt)
  );

  function automatic stim_t s_nop();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t s_lu_rs(input logic [4:0] r);
    stim_t s;
    s = '0; s.rs = r; s.use_rs = 1'b1; s.ex_rd = 1'b1; s.ex_w = r;
    return s;
  endfunction

  function automatic stim_t s_lu_rt(input logic [4:0] r);
    stim_t s;
    s = '0; s.rt = r; s.use_rt = 1'b1; s.ex_rd = 1'b1; s.ex_w = r;
    return s;
  endfunction

  function automatic stim_t s_md(input logic div);
    stim_t s;
    s = '0; s.md_op = 1'b1; s.md_div = div; s.use_rs = 1'b1; s.rs = 5'd4; s.use_rt = 1'b1; s.rt = 5'd5;
    return s;
  endfunction

  function automatic stim_t s_hilo();
    stim_t s;
    s = '0; s.hilo = 1'b1;
    return s;
  endfunction

  function automatic stim_t s_br();
    stim_t s;
    s = '0; s.br = 1'b1;
    return s;
  endfunction

  // One cycle: apply stimulus just after the rising edge and queue its expected response
  task automatic cyc(input string nm, input stim_t s, input logic [5:0] eb, input logic [CW-1:0] ec);
    exp_t e;
    @(posedge CLK);
    #1;
    reset       = s.rst;
    id_rs       = s.rs;
    id_rt       = s.rt;
    id_use_rs   = s.use_rs;
    id_use_rt   = s.use_rt;
    id_md_op    = s.md_op;
    id_md_div   = s.md_div;
    id_hilo_acc = s.hilo;
    id_br_taken = s.br;
    ex_mem_read = s.ex_rd;
    ex_wreg     = s.ex_w;
    e.bits = eb;
    e.cnt  = ec;
    e.nm   = nm;
    q.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents a full control word; check it on the falling edge
  initial begin
    exp_t e;
    logic [5:0] act;
    forever begin
      @(negedge CLK);
      if (q.size() != 0) begin
        e = q.pop_front();
        act = {pc_bubble, ifid_stall, ifid_flush, idex_flush, md_start, md_busy};
        checks++;
        if (act !== e.bits || stall_cnt !== e.cnt) begin
          failures++;
          $display("FAIL %s: got bits=%b cnt=%0d, expected bits=%b cnt=%0d",
                   e.nm, act, stall_cnt, e.bits, e.cnt);
        end
      end
    end
  end

  initial begin
    stim_t s;
    reset = 1'b1;
    id_rs = '0; id_rt = '0; ex_wreg = '0;
    id_use_rs = 0; id_use_rt = 0; id_md_op = 0; id_md_div = 0;
    id_hilo_acc = 0; id_br_taken = 0; ex_mem_read = 0;

    // Reset holds everything low, even with a live load-use hazard
    s = s_nop();       s.rst = 1'b1; cyc("reset_idle", s, E_NONE, 0);
    s = s_lu_rs(5'd8); s.rst = 1'b1; cyc("reset_masks_hazard", s, E_NONE, 0);
    cyc("idle", s_nop(), E_NONE, 0);

    // Load-use on rs and rt: exactly one stall cycle each
    cyc("lu_rs", s_lu_rs(5'd8), E_STALL, 0);
    cyc("lu_rs_after", s_nop(), E_NONE, 1);
    cyc("lu_rt", s_lu_rt(5'd9), E_STALL, 1);
    cyc("lu_rt_after", s_nop(), E_NONE, 2);

    // Near-misses: different register, not a load, $0, operand not read
    s = s_lu_rs(5'd8); s.ex_w = 5'd9;      cyc("lu_diff_reg", s, E_NONE, 2);
    s = s_lu_rs(5'd8); s.ex_rd = 1'b0;     cyc("lu_not_load", s, E_NONE, 2);
    cyc("lu_reg0", s_lu_rs(5'd0), E_NONE, 2);
    s = s_lu_rs(5'd8); s.use_rs = 1'b0;    cyc("lu_rs_unused", s, E_NONE, 2);

    // MULT then MFHI: 4 stall cycles, then MFHI passes
    cyc("mult_start", s_md(1'b0), E_START, 2);
    for (int i = 0; i < 4; i++) cyc("mfhi_stall", s_hilo(), E_STALLB, CW'(2 + i));
    cyc("mfhi_pass", s_hilo(), E_NONE, 6);

    // DIV then DIV: 9 stall cycles (counter saturates at 15), then second DIV starts
    cyc("div1_start", s_md(1'b1), E_START, 6);
    for (int i = 0; i < 9; i++) cyc("div2_stall", s_md(1'b1), E_STALLB, CW'(6 + i));
    cyc("div2_start", s_md(1'b1), E_START, 15);
    for (int i = 0; i < 9; i++) cyc("div2_busy", s_nop(), E_BUSY, 15);
    cyc("div2_done", s_nop(), E_NONE, 15);

    // Branch flush alone; suppressed by a concurrent load-use; counter stays saturated
    cyc("br_flush", s_br(), E_FLUSH, 15);
    s = s_lu_rs(5'd3); s.br = 1'b1;        cyc("br_with_lu", s, E_STALL, 15);
    cyc("br_represent", s_br(), E_FLUSH, 15);

    // MD op with load-use waits; starts the following cycle
    s = s_md(1'b0); s.ex_rd = 1'b1; s.ex_w = 5'd4; cyc("md_lu_block", s, E_STALL, 15);
    cyc("md_after_lu", s_md(1'b0), E_START, 15);
    cyc("br_while_busy", s_br(), E_FLUSH | E_BUSY, 15);
    for (int i = 0; i < 3; i++) cyc("mult_busy", s_nop(), E_BUSY, 15);
    cyc("mult_done", s_nop(), E_NONE, 15);

    // Reset three cycles into a DIV aborts it and clears the counter
    cyc("div_start", s_md(1'b1), E_START, 15);
    cyc("div_busy1", s_nop(), E_BUSY, 15);
    cyc("div_busy2", s_nop(), E_BUSY, 15);
    s = s_hilo(); s.rst = 1'b1;            cyc("div_reset", s, E_NONE, 15);
    cyc("mflo_after_reset", s_hilo(), E_NONE, 0);
    cyc("lu_after_reset", s_lu_rs(5'd12), E_STALL, 0);
    cyc("final_idle", s_nop(), E_NONE, 1);

    // Drain: the monitor must consume every queued expectation within a few cycles
    for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge CLK);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
